stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, WIDTH-bit streaming multiplexer with valid/ready handshakes on every channel, a registered output stage, and two selection modes: fixed select (classic mux behaviour) or round-robin arbitration. It sits wherever several producer streams merge onto one consumer, such as a shared bus or result port. It generalises the combinational 2:1 mux into a back-pressure-aware, fair, pipelined selector.

## Interface
- NUM_INPUTS, 4, number of input channels (≥1; need not be a power of two)
- WIDTH, 8, data width per channel in bits
- SEL_W, max(1, $clog2(NUM_INPUTS)), derived localparam; width of select/channel fields

- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous and active-high
- in_data  in  [NUM_INPUTS][WIDTH]  per-channel data
- in_valid  in  [NUM_INPUTS]  per-channel valid
- in_ready  out  [NUM_INPUTS]  per-channel ready; combinational
- fixed_en  in  1  1 = fixed-select mode, 0 = round-robin mode
- sel  in  SEL_W  channel selected when fixed_en=1
- out_data  out  WIDTH  registered output data
- out_chan  out  SEL_W  registered index of the channel out_data came from
- out_valid  out  1  registered output valid
- out_ready  in  1  downstream ready

## Operation
- Transfer on a channel: valid & ready both high at posedge.
- Output stage: one-entry register. can_load = !out_valid | out_ready.
- Grant (combinational, one-hot or none):
  - fixed_en=1: grant channel sel if in_valid[sel]; no grant if sel ≥ NUM_INPUTS.
  - fixed_en=0: first valid channel scanning last_grant+1, +2, … wrapping modulo NUM_INPUTS; last_grant itself is lowest priority.
- in_ready[g] = grant[g] & can_load; all other in_ready = 0. in_ready never depends on out_valid of other channels' data.
- On accept: out_data ← in_data[g], out_chan ← g, out_valid ← 1, last_grant ← g.
- Output pop (out_valid & out_ready) with no accept: out_valid ← 0; out_data/out_chan hold.
- last_grant updates only on accept, in both modes (fixed-mode traffic affects subsequent round-robin order).
- No combinational path from in_* to out_*.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, last_grant=NUM_INPUTS-1 (channel 0 has first priority after reset). in_ready follows combinationally: with no stored data, in_ready is high only for the granted channel.
- Latency: accept at edge k → out_valid/out_data visible after edge k, consumed at earliest edge k+1.
- Throughput: one word per cycle with out_ready held high (simultaneous pop and accept at one edge loads the new word).
- Stall: out_valid=1 & out_ready=0 → out_data, out_chan stable; all in_ready=0.
- fixed_en or sel changes take effect on the same cycle's grant; a word already in the output register is unaffected.
- Input data may change while in_valid=0; a channel with in_valid=1 and no grant must hold data (AXI-style; not checked by the block).
- rst asserted mid-operation: the held word is discarded at that edge, all registers take reset values, and in_ready is 0 during the rst cycle.
- NUM_INPUTS=1: sel ignored beyond bit 0 compare, round-robin degenerates to pass-through with one-cycle register.

## Structure
- Package stream_mux_pkg: function sel_width(n) returning max(1,$clog2(n)); shared by DUT and bench.
- Sub-module rr_arbiter (NUM_INPUTS): inputs req, last_grant; output one-hot grant. Purely combinational rotate–priority-encode–rotate-back. Fixed-mode override and output register live in stream_mux_rr.

## Test plan
- Reset, then fixed_en=1, sel=2, only in_valid[2]=1 with data 0xA5, out_ready=1 → out_valid=1, out_data=0xA5, out_chan=2 one edge later; in_ready=4'b0100.
- Round-robin, all four valid continuously, out_ready=1 → out_chan sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
- Round-robin, channels 1 and 3 valid, out_ready=0 for 3 cycles after first accept → out_data/out_chan frozen at channel 1's word, all in_ready=0; on release next word comes from channel 3.
- Fixed mode, sel=1 with in_valid[1]=0 and in_valid[0]=1 → no grant, in_ready=0, out_valid stays 0; sel=5 with NUM_INPUTS=5 (non-power-of-two instance) → no grant.
- Exhaustive sweep in fixed mode (successor of the 2:1 check): for NUM_INPUTS=2, WIDTH=1, all 8 combinations of in_data[0], in_data[1], sel with both valid → out_data equals sel ? in_data[1] : in_data[0] one cycle later.
- Assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, out_chan=0; first post-reset round-robin grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_pkg
// Description : Shared helpers for the round-robin stream multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================

package stream_mux_pkg;

    // Width of a channel index; a single-channel mux still carries one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter (rotate, priority-encode,
//               rotate back); the last granted channel has lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================

module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [SEL_W-1:0]      last_grant,
    output logic [NUM_INPUTS-1:0] grant
);

    logic [SEL_W-1:0]      w_start;
    logic [NUM_INPUTS-1:0] w_req_rot;
    logic [NUM_INPUTS-1:0] w_gnt_rot;
    logic                  w_found;

    // Scanning starts just past the previous winner, wrapping modulo NUM_INPUTS.
    always_comb begin
        if (last_grant >= SEL_W'(NUM_INPUTS - 1)) begin
            w_start = '0;
        end else begin
            w_start = last_grant + SEL_W'(1);
        end
    end

    always_comb begin
        w_req_rot = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_req_rot[i] = req[(int'(w_start) + i) % NUM_INPUTS];
        end
    end

    always_comb begin
        w_gnt_rot = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_req_rot[i] && !w_found) begin
                w_gnt_rot[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant[(int'(w_start) + i) % NUM_INPUTS] = w_gnt_rot[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-input valid/ready stream mux with fixed-select or
//               round-robin arbitration and a one-entry registered output.
// Revision    : 1.0 - initial release
// ============================================================================

module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int WIDTH      = 8,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0][WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic                             fixed_en,
    input  logic [SEL_W-1:0]                 sel,
    output logic [WIDTH-1:0]                 out_data,
    output logic [SEL_W-1:0]                 out_chan,
    output logic                             out_valid,
    input  logic                             out_ready
);

    logic [NUM_INPUTS-1:0] w_rr_grant;
    logic [NUM_INPUTS-1:0] w_fix_grant;
    logic [NUM_INPUTS-1:0] w_grant;
    logic                  w_can_load;
    logic                  w_accept;
    logic [SEL_W-1:0]      w_grant_idx;
    logic [WIDTH-1:0]      w_grant_data;

    logic [WIDTH-1:0]      r_out_data;
    logic [SEL_W-1:0]      r_out_chan;
    logic                  r_out_valid;
    logic [SEL_W-1:0]      r_last_grant;

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_rr_arbiter (
        .req        (in_valid),
        .last_grant (r_last_grant),
        .grant      (w_rr_grant)
    );

    // An out-of-range sel matches no channel, so it produces no grant.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_fix_grant
            assign w_fix_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
        end
    endgenerate

    assign w_grant    = fixed_en ? w_fix_grant : w_rr_grant;
    assign w_can_load = !r_out_valid || out_ready;
    assign in_ready   = (w_can_load && !rst) ? w_grant : '0;
    assign w_accept   = |in_ready;

    always_comb begin
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = w_grant_idx | SEL_W'(i);
                w_grant_data = w_grant_data | in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_out_valid  <= 1'b0;
            r_last_grant <= SEL_W'(NUM_INPUTS - 1);
        end else if (w_accept) begin
            r_out_data   <= w_grant_data;
            r_out_chan   <= w_grant_idx;
            r_out_valid  <= 1'b1;
            r_last_grant <= w_grant_idx;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Directed self-checking bench for stream_mux_rr (4, 5 and
//               2-input instances sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 4-input, 8-bit instance
    logic [3:0][7:0] in_data4;
    logic [3:0]      in_valid4;
    logic [3:0]      in_ready4;
    logic            fixed_en4;
    logic [1:0]      sel4;
    logic [7:0]      out_data4;
    logic [1:0]      out_chan4;
    logic            out_valid4;
    logic            out_ready4;

    // 5-input, 8-bit instance
    logic [4:0][7:0] in_data5;
    logic [4:0]      in_valid5;
    logic [4:0]      in_ready5;
    logic            fixed_en5;
    logic [2:0]      sel5;
    logic [7:0]      out_data5;
    logic [2:0]      out_chan5;
    logic            out_valid5;
    logic            out_ready5;

    // 2-input, 1-bit instance
    logic [1:0][0:0] in_data2;
    logic [1:0]      in_valid2;
    logic [1:0]      in_ready2;
    logic            fixed_en2;
    logic [0:0]      sel2;
    logic [0:0]      out_data2;
    logic [0:0]      out_chan2;
    logic            out_valid2;
    logic            out_ready2;

    int n_asserts = 0;
    int n_fail    = 0;

    stream_mux_rr #(.NUM_INPUTS(4), .WIDTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .fixed_en(fixed_en4), .sel(sel4),
        .out_data(out_data4), .out_chan(out_chan4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    stream_mux_rr #(.NUM_INPUTS(5), .WIDTH(8)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .fixed_en(fixed_en5), .sel(sel5),
        .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
        .out_ready(out_ready5)
    );

    stream_mux_rr #(.NUM_INPUTS(2), .WIDTH(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .fixed_en(fixed_en2), .sel(sel2),
        .out_data(out_data2), .out_chan(out_chan2), .out_valid(out_valid2),
        .out_ready(out_ready2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out4(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({tag, ".valid"}, 32'(out_valid4), 32'(v));
        check({tag, ".data"},  32'(out_data4),  32'(d));
        check({tag, ".chan"},  32'(out_chan4),  32'(c));
    endtask

    initial begin
        in_data4 = '0; in_valid4 = '0; fixed_en4 = 1'b0; sel4 = '0; out_ready4 = 1'b0;
        in_data5 = '0; in_valid5 = '0; fixed_en5 = 1'b0; sel5 = '0; out_ready5 = 1'b0;
        in_data2 = '0; in_valid2 = '0; fixed_en2 = 1'b0; sel2 = '0; out_ready2 = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_out4("reset", 1'b0, 8'h00, 2'd0);
        check("reset.in_ready", 32'(in_ready4), 32'h0);

        // Fixed select, channel 2 only
        fixed_en4 = 1'b1; sel4 = 2'd2; out_ready4 = 1'b1;
        in_valid4 = 4'b0100; in_data4[2] = 8'hA5;
        #1;
        check("fix2.in_ready", 32'(in_ready4), 32'b0100);
        tick();
        check_out4("fix2.out", 1'b1, 8'hA5, 2'd2);
        in_valid4 = '0;
        tick();
        check("fix2.pop", 32'(out_valid4), 32'h0);

        // Round-robin, all valid, full throughput from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fixed_en4 = 1'b0; out_ready4 = 1'b1; in_valid4 = 4'b1111;
        in_data4 = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        check("rr.first_ready", 32'(in_ready4), 32'b0001);
        tick(); check_out4("rr.c0", 1'b1, 8'h10, 2'd0);
        tick(); check_out4("rr.c1", 1'b1, 8'h11, 2'd1);
        tick(); check_out4("rr.c2", 1'b1, 8'h12, 2'd2);
        tick(); check_out4("rr.c3", 1'b1, 8'h13, 2'd3);
        tick(); check_out4("rr.c4", 1'b1, 8'h10, 2'd0);
        tick(); check_out4("rr.c5", 1'b1, 8'h11, 2'd1);
        in_valid4 = '0;
        tick();
        check("rr.drain", 32'(out_valid4), 32'h0);

        // Round-robin stall with channels 1 and 3 requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready4 = 1'b0; in_valid4 = 4'b1010;
        in_data4 = {8'h23, 8'h00, 8'h21, 8'h00};
        #1;
        check("stall.ready0", 32'(in_ready4), 32'b0010);
        tick();
        check_out4("stall.load", 1'b1, 8'h21, 2'd1);
        in_data4[1] = 8'h31;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.in_ready", 32'(in_ready4), 32'h0);
            tick();
            check_out4("stall.hold", 1'b1, 8'h21, 2'd1);
        end
        out_ready4 = 1'b1;
        #1;
        check("stall.release_ready", 32'(in_ready4), 32'b1000);
        tick();
        check_out4("stall.next", 1'b1, 8'h23, 2'd3);
        in_valid4 = '0;
        tick();
        check("stall.drain", 32'(out_valid4), 32'h0);

        // Fixed select of an idle channel: no grant even though channel 0 is valid
        fixed_en4 = 1'b1; sel4 = 2'd1; in_valid4 = 4'b0001; in_data4[0] = 8'h5A;
        #1;
        check("fixidle.in_ready", 32'(in_ready4), 32'h0);
        tick();
        check("fixidle.valid", 32'(out_valid4), 32'h0);
        in_valid4 = '0;

        // Five-input instance: out-of-range sel, then the top channel
        fixed_en5 = 1'b1; out_ready5 = 1'b1; sel5 = 3'd5; in_valid5 = 5'b11111;
        in_data5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        #1;
        check("n5.sel5_ready", 32'(in_ready5), 32'h0);
        tick();
        check("n5.sel5_valid", 32'(out_valid5), 32'h0);
        sel5 = 3'd4;
        #1;
        check("n5.sel4_ready", 32'(in_ready5), 32'b10000);
        tick();
        check("n5.sel4_valid", 32'(out_valid5), 32'h1);
        check("n5.sel4_data", 32'(out_data5), 32'h44);
        check("n5.sel4_chan", 32'(out_chan5), 32'd4);
        in_valid5 = '0;

        // Two-input one-bit sweep of data and select
        fixed_en2 = 1'b1; out_ready2 = 1'b1; in_valid2 = 2'b11;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = 3'(v);
            in_data2[0] = vec[0];
            in_data2[1] = vec[1];
            sel2 = vec[2];
            tick();
            check($sformatf("mux2.v%0d", v), 32'(out_data2), 32'(vec[2] ? vec[1] : vec[0]));
        end
        in_valid2 = '0;

        // Reset while a word is stalled in the output register
        fixed_en4 = 1'b0; out_ready4 = 1'b0; in_valid4 = 4'b0100;
        in_data4 = {8'h13, 8'h77, 8'h11, 8'h10};
        tick();
        check_out4("rststall.load", 1'b1, 8'h77, 2'd2);
        in_valid4 = 4'b1111;
        rst = 1'b1;
        #1;
        check("rststall.rst_ready", 32'(in_ready4), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check_out4("rststall.cleared", 1'b0, 8'h00, 2'd0);
        in_data4[2] = 8'h12;
        out_ready4 = 1'b1;
        #1;
        check("rststall.first_ready", 32'(in_ready4), 32'b0001);
        tick();
        check_out4("rststall.first", 1'b1, 8'h10, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
